// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared state encoding, defaults and hazard helpers for hazard_ctrl.
package hazard_ctrl_pkg;

  localparam int RSV_TIMEOUT_DEF = 64;
  localparam int REG_AW          = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MEM_WAIT = 3'd1,
    ST_DIV_WAIT = 3'd2,
    ST_AMO_RD   = 3'd3,
    ST_AMO_WR   = 3'd4
  } hz_state_e;

  // A load in EX whose result an ID source needs cannot be forwarded until after MEM.
  function automatic logic load_use_hit(
    input logic              memread,
    input logic [REG_AW-1:0] rd,
    input logic [REG_AW-1:0] rs1,
    input logic [REG_AW-1:0] rs2,
    input logic              uses_rs1,
    input logic              uses_rs2
  );
    return memread && (rd != '0) &&
           (((rd == rs1) && uses_rs1) || ((rd == rs2) && uses_rs2));
  endfunction

endpackage

// File: rtl/lrsc_reservation.sv
// rtl/lrsc_reservation.sv - LR/SC word reservation; idle expiry only with HAZARD_RSV_TIMEOUT_EN.
module lrsc_reservation
  import hazard_ctrl_pkg::*;
#(
  parameter int XLEN = 32
`ifdef HAZARD_RSV_TIMEOUT_EN
  , parameter int RSV_TIMEOUT = RSV_TIMEOUT_DEF
`endif
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            mem_done_i,
  input  logic            is_lr_i,
  input  logic            is_sc_i,
  input  logic            store_i,
  input  logic            is_amo_i,
  input  logic [XLEN-3:0] word_addr_i,
  output logic            reserved_o,
  output logic            sc_success_o
);

  logic            rsv_q, rsv_d;
  logic [XLEN-3:0] rsv_addr_q, rsv_addr_d;
  logic            addr_match;

  assign addr_match = (rsv_addr_q == word_addr_i);

`ifdef HAZARD_RSV_TIMEOUT_EN
  localparam logic [7:0] RSV_TIMEOUT_W = 8'(RSV_TIMEOUT);
  logic [7:0] cnt_q, cnt_d;
`endif

  always_comb begin
    rsv_d      = rsv_q;
    rsv_addr_d = rsv_addr_q;
    if (mem_done_i) begin
      if (is_lr_i) begin
        rsv_d      = 1'b1;
        rsv_addr_d = word_addr_i;
      end else if (is_sc_i) begin
        rsv_d = 1'b0;
      end else if ((store_i || is_amo_i) && addr_match) begin
        rsv_d = 1'b0;
      end
    end
`ifdef HAZARD_RSV_TIMEOUT_EN
    cnt_d = '0;
    if (!(mem_done_i && is_lr_i) && rsv_q) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == RSV_TIMEOUT_W) rsv_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsv_q      <= 1'b0;
      rsv_addr_q <= '0;
`ifdef HAZARD_RSV_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      rsv_q      <= rsv_d;
      rsv_addr_q <= rsv_addr_d;
`ifdef HAZARD_RSV_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign reserved_o   = rsv_q;
  assign sc_success_o = is_sc_i && rsv_q && addr_match;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencer with multi-cycle FSM and LR/SC reservation.
// HAZARD_RSV_TIMEOUT_EN enables expiry of an idle reservation after RSV_TIMEOUT cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int XLEN = 32
`ifdef HAZARD_RSV_TIMEOUT_EN
  , parameter int RSV_TIMEOUT = RSV_TIMEOUT_DEF
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] ID_rs1,
  input  logic [REG_AW-1:0] ID_rs2,
  input  logic              ID_uses_rs1,
  input  logic              ID_uses_rs2,
  input  logic [REG_AW-1:0] ID_EX_rd,
  input  logic              ID_EX_memread,
  input  logic              ID_EX_div,
  input  logic              div_done,
  input  logic              branch_taken,
  input  logic              EX_MEM_memreq,
  input  logic              EX_MEM_store,
  input  logic              EX_MEM_is_lr,
  input  logic              EX_MEM_is_sc,
  input  logic              EX_MEM_is_amo,
  input  logic [XLEN-1:0]   EX_MEM_addr,
  input  logic              dmem_ready,
  output logic              stall_PC,
  output logic              stall_IF_ID,
  output logic              stall_ID_EX,
  output logic              stall_EX_MEM,
  output logic              flush_IF_ID,
  output logic              flush_ID_EX,
  output logic              amo_we,
  output logic              reserved,
  output logic              sc_success
);

  hz_state_e state_q, state_d;
  logic st_pc, st_ifid, st_idex, st_exmem, fl_ifid, fl_idex;
  logic idle_like, load_use;
  logic rsv, sc_ok;
  logic addr_lsb_unused;

  assign load_use = load_use_hit(ID_EX_memread, ID_EX_rd, ID_rs1, ID_rs2,
                                 ID_uses_rs1, ID_uses_rs2);
  assign addr_lsb_unused = ^EX_MEM_addr[1:0];

  always_comb begin
    state_d   = state_q;
    st_pc     = 1'b0;
    st_ifid   = 1'b0;
    st_idex   = 1'b0;
    st_exmem  = 1'b0;
    fl_ifid   = 1'b0;
    fl_idex   = 1'b0;
    idle_like = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (EX_MEM_is_amo) begin
          state_d = ST_AMO_RD;
          {st_pc, st_ifid, st_idex, st_exmem} = 4'hF;
        end else if (EX_MEM_memreq && !dmem_ready) begin
          state_d = ST_MEM_WAIT;
          {st_pc, st_ifid, st_idex, st_exmem} = 4'hF;
        end else begin
          idle_like = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) idle_like = 1'b1;
        else {st_pc, st_ifid, st_idex, st_exmem} = 4'hF;
      end
      ST_DIV_WAIT: begin
        if (div_done) idle_like = 1'b1;
        else {st_pc, st_ifid, st_idex} = 3'h7;
      end
      ST_AMO_RD: begin
        {st_pc, st_ifid, st_idex, st_exmem} = 4'hF;
        if (dmem_ready) state_d = ST_AMO_WR;
      end
      ST_AMO_WR: begin
        if (dmem_ready) idle_like = 1'b1;
        else {st_pc, st_ifid, st_idex, st_exmem} = 4'hF;
      end
      default: state_d = ST_IDLE;
    endcase

    // Completion cycles release EX, so the EX/ID-side hazards are decoded there as in IDLE.
    if (idle_like) begin
      state_d = ST_IDLE;
      if (ID_EX_div && !div_done) begin
        state_d = ST_DIV_WAIT;
        {st_pc, st_ifid, st_idex} = 3'h7;
      end else if (branch_taken) begin
        fl_ifid = 1'b1;
        fl_idex = 1'b1;
      end else if (load_use) begin
        st_pc   = 1'b1;
        st_ifid = 1'b1;
        fl_idex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  lrsc_reservation #(
    .XLEN(XLEN)
`ifdef HAZARD_RSV_TIMEOUT_EN
    , .RSV_TIMEOUT(RSV_TIMEOUT)
`endif
  ) u_rsv (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_done_i  (EX_MEM_memreq && dmem_ready),
    .is_lr_i     (EX_MEM_is_lr),
    .is_sc_i     (EX_MEM_is_sc),
    .store_i     (EX_MEM_store),
    .is_amo_i    (EX_MEM_is_amo),
    .word_addr_i (EX_MEM_addr[XLEN-1:2]),
    .reserved_o  (rsv),
    .sc_success_o(sc_ok)
  );

  // Outputs are forced low while reset is held, independent of the live inputs.
  assign stall_PC     = st_pc    && reset_n;
  assign stall_IF_ID  = st_ifid  && reset_n;
  assign stall_ID_EX  = st_idex  && reset_n;
  assign stall_EX_MEM = st_exmem && reset_n;
  assign flush_IF_ID  = fl_ifid  && reset_n;
  assign flush_ID_EX  = fl_idex  && reset_n;
  assign amo_we       = (state_q == ST_AMO_WR) && reset_n;
  assign reserved     = rsv   && reset_n;
  assign sc_success   = sc_ok && reset_n;

endmodule
